// File: rtl/table_writer_ram.sv
// Loadable lookup table: a valid/ready loader fills it in order, and NPORTS combinational read ports serve the predictor lanes.
// Latency: one write per cycle in LOAD, loaded rises on the edge that takes the last entry; reads are zero-latency.
// Backpressure: wr_ready is high only in LOAD, and wr_valid low stalls the loader for as long as needed.
module table_writer_ram #(
    parameter int DATAWIDTH = 2,
    parameter int DEPTHBITS = 3,
    parameter int DATADEPTH = 1 << DEPTHBITS,
    parameter int NPORTS    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           wr_valid,
    input  logic [DATAWIDTH-1:0]           wr_data,
    output logic                           wr_ready,
    output logic [DEPTHBITS-1:0]           wr_addr,
    output logic                           loading,
    output logic                           loaded,
    input  logic [NPORTS*DEPTHBITS-1:0]    rd_addr,
    output logic [NPORTS*DATAWIDTH-1:0]    rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DEPTHBITS-1:0] LAST_ADDR = DEPTHBITS'(DATADEPTH - 1);

    state_t               state;
    logic [DATAWIDTH-1:0] mem [DATADEPTH];

    assign wr_ready = (state == LOAD);
    assign loading  = (state == LOAD);

    // start outranks a same-cycle beat, so a restart never writes the beat it collides with
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_addr <= '0;
            loaded  <= 1'b0;
            for (int i = 0; i < DATADEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        wr_addr <= '0;
                        loaded  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (start) begin
                        wr_addr <= '0;
                        loaded  <= 1'b0;
                    end else if (wr_valid) begin
                        mem[wr_addr] <= wr_data;
                        wr_addr      <= wr_addr + 1'b1;
                        if (wr_addr == LAST_ADDR) begin
                            loaded <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state   <= LOAD;
                        wr_addr <= '0;
                        loaded  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NPORTS; k++) begin : g_rd
        assign rd_data[k*DATAWIDTH +: DATAWIDTH] = mem[rd_addr[k*DEPTHBITS +: DEPTHBITS]];
    end

endmodule

// File: tb/tb_table_writer_ram.sv
// Directed bench for table_writer_ram: reset, loads with and without bubbles, restart, DONE lockout, reset mid-load.
module tb_table_writer_ram;

    localparam int DW = 2;
    localparam int AB = 3;
    localparam int NP = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               wr_valid;
    logic [DW-1:0]      wr_data;
    logic               wr_ready;
    logic [AB-1:0]      wr_addr;
    logic               loading;
    logic               loaded;
    logic [NP*AB-1:0]   rd_addr;
    logic [NP*DW-1:0]   rd_data;

    int checks = 0;
    int errors = 0;

    table_writer_ram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .loading  (loading),
        .loaded   (loaded),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd_all(input int a);
        for (int k = 0; k < NP; k++) rd_addr[k*AB +: AB] = AB'(a);
        #1;
    endtask

    // port k reads address k%8
    task automatic set_rd_mod();
        for (int k = 0; k < NP; k++) rd_addr[k*AB +: AB] = AB'(k % 8);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [31:0] expv;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_addr  = '0;
        #12;
        rst_n = 1'b1;
        tick();

        // 1: asynchronous reset asserted mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_loaded",   32'(loaded),   32'd0);
        chk("rst_wr_addr",  32'(wr_addr),  32'd0);
        chk("rst_loading",  32'(loading),  32'd0);
        for (int a = 0; a < 8; a++) begin
            set_rd_all(a);
            chk($sformatf("rst_rd_a%0d", a), rd_data, 32'h0);
        end
        tick();
        rst_n = 1'b1;
        tick();

        // 2: full continuous load 0,1,2,3,0,1,2,3
        do_start();
        chk("ld_loading", 32'(loading), 32'd1);
        chk("ld_ready",   32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = DW'(i % 4);
            tick();
            if (i == 2) chk("ld_addr3", 32'(wr_addr), 32'd3);
            if (i == 6) chk("ld_notyet", 32'(loaded), 32'd0);
        end
        wr_valid = 1'b0;
        chk("ld_loaded", 32'(loaded),   32'd1);
        chk("ld_ready0", 32'(wr_ready), 32'd0);
        chk("ld_wrap",   32'(wr_addr),  32'd0);
        set_rd_mod();
        expv = '0;
        for (int k = 0; k < NP; k++) expv[k*DW +: DW] = DW'(k % 4);
        chk("ld_rd", rd_data, expv);

        // 3: bubbles, data for beat b is 3-(b%4)
        do_start();
        chk("bb_loaded0", 32'(loaded), 32'd0);
        for (int c = 0; c < 16; c++) begin
            wr_valid = (c % 2 == 0);
            wr_data  = DW'(3 - ((c / 2) % 4));
            tick();
            if (c == 5)  chk("bb_addr_c5", 32'(wr_addr), 32'd3);
            if (c == 6)  chk("bb_addr_c6", 32'(wr_addr), 32'd4);
            if (c == 13) chk("bb_notyet",  32'(loaded),  32'd0);
            if (c == 14) chk("bb_loaded",  32'(loaded),  32'd1);
        end
        wr_valid = 1'b0;
        set_rd_mod();
        expv = '0;
        for (int k = 0; k < NP; k++) expv[k*DW +: DW] = DW'(3 - (k % 4));
        chk("bb_rd", rd_data, expv);

        // 4: restart mid-load; colliding 2'b01 beat must be dropped
        do_start();
        for (int i = 0; i < 5; i++) beat(2'b11);
        chk("rs_addr5", 32'(wr_addr), 32'd5);
        start    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 2'b01;
        tick();
        start    = 1'b0;
        wr_valid = 1'b0;
        chk("rs_addr0",   32'(wr_addr), 32'd0);
        chk("rs_loading", 32'(loading), 32'd1);
        chk("rs_loaded",  32'(loaded),  32'd0);
        set_rd_all(5);
        chk("rs_a5_old", 32'(rd_data[1:0]), 32'd2);
        set_rd_all(4);
        chk("rs_a4_new", 32'(rd_data[1:0]), 32'd3);
        for (int i = 0; i < 8; i++) begin
            beat(2'b10);
            if (i == 6) chk("rs_notyet", 32'(loaded), 32'd0);
        end
        chk("rs_done", 32'(loaded), 32'd1);
        set_rd_mod();
        chk("rs_rd", rd_data, {16{2'b10}});

        // 5: DONE ignores writes
        wr_valid = 1'b1;
        wr_data  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("dn_ready%0d", i),  32'(wr_ready), 32'd0);
            chk($sformatf("dn_loaded%0d", i), 32'(loaded),   32'd1);
        end
        wr_valid = 1'b0;
        set_rd_mod();
        chk("dn_rd", rd_data, {16{2'b10}});

        // 6: reset after 3 beats, then stray beats with no start
        do_start();
        for (int i = 0; i < 3; i++) beat(2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_loaded",  32'(loaded),  32'd0);
        chk("mr_loading", 32'(loading), 32'd0);
        chk("mr_addr",    32'(wr_addr), 32'd0);
        set_rd_mod();
        chk("mr_rd", rd_data, 32'h0);
        tick();
        rst_n    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 2'b11;
        for (int i = 0; i < 4; i++) tick();
        wr_valid = 1'b0;
        chk("mr_idle_ready", 32'(wr_ready), 32'd0);
        chk("mr_idle_addr",  32'(wr_addr),  32'd0);
        chk("mr_idle_rd",    rd_data,       32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/table_writer_ram.md
Name: table_writer_ram

Overview:
- Loadable multi-read-port lookup table: the write-side counterpart of the read-only multi-port table.
- A sequential loader accepts a valid/ready stream of table entries, writes them at an auto-incrementing address, and flags completion.
- NPORTS independent combinational read ports serve the parallel predictor lanes.
- The table is rewritten at run time, for example when new coefficients arrive, instead of being fixed at elaboration.

Parameters:
- DATAWIDTH, 2, bits per table entry.
- DEPTHBITS, 3, address width.
- DATADEPTH, 1<<DEPTHBITS, number of entries.
- NPORTS, 16, number of read ports.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load at address 0.
- wr_valid  input  1  wr_data holds a valid entry.
- wr_data  input  DATAWIDTH  entry to write.
- wr_ready  output  1  loader accepts a beat this cycle.
- wr_addr  output  DEPTHBITS  address the next accepted beat writes to.
- loading  output  1  high while in state LOAD.
- loaded  output  1  table fully written since the last start.
- rd_addr  input  NPORTS*DEPTHBITS  flattened read addresses; port k uses bits [k*DEPTHBITS +: DEPTHBITS].
- rd_data  output  NPORTS*DATAWIDTH  flattened read data; port k uses bits [k*DATAWIDTH +: DATAWIDTH].

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all mem entries=0; wr_addr=0; loaded=0.
  - wr_ready=0 and loading=0, because both decode from state.
- Beat acceptance: a beat is accepted when wr_valid & wr_ready at a rising edge of clk.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - wr_ready=0.
  - start -> LOAD with wr_addr<=0 and loaded<=0.
- LOAD:
  - wr_ready=1, loading=1.
  - Each accepted beat: mem[wr_addr]<=wr_data, then wr_addr<=wr_addr+1.
  - Accepted beat with wr_addr==DATADEPTH-1: write the entry, wr_addr wraps to 0, loaded<=1, state -> DONE.
  - wr_valid low: hold state and address; no timeout.
- DONE:
  - wr_ready=0; loaded holds 1.
  - wr_valid is ignored and mem is unchanged.
  - start -> LOAD with wr_addr<=0 and loaded<=0.
- start during LOAD:
  - Restarts at wr_addr 0.
  - start has priority over a beat in the same cycle: that beat is not written.
  - Earlier writes remain in mem until overwritten.
- Read ports:
  - rd_data[k] = mem[rd_addr[k]], purely combinational, zero latency, in every state.
  - A read of an address written on the same edge returns the old value before the edge and the new value after it.
  - Reads during LOAD return a mix of new and previous contents. Consumers must qualify reads with loaded.
- Width rules:
  - wr_addr is DEPTHBITS wide and wraps modulo DATADEPTH.
  - No partial-width writes.
  - All read ports share the single mem array.
- Reset mid-LOAD: everything returns to reset values, including mem=0. A new start is required to load.
- Only one write port exists; there are no write/write conflicts.

Test Plan:
1. Reset check: assert rst_n=0 mid-cycle, then check asynchronously that wr_ready=0, loaded=0, wr_addr=0, and that all 16 rd_data ports read 0 for every address.
2. Full load with defaults, continuous stream:
   - Stimulus: start, then wr_valid=1 for 8 cycles with data 0,1,2,3,0,1,2,3.
   - loaded rises the cycle after the 8th beat; wr_ready falls.
   - Port k reading addr k%8 returns k%4.
3. Bubbles: toggle wr_valid 1,0,1,0…
   - wr_addr advances only on accepted beats.
   - loaded rises only after the 8th accepted beat, 16 cycles after start.
4. Restart mid-load:
   - Stimulus: start, write 5 beats of 2'b11, pulse start together with a beat of 2'b01, then load 8 beats of 2'b10.
   - The 2'b01 beat is not written; all entries read 2'b10; loaded=1 only at the end.
5. DONE ignores writes: after a full load, drive wr_valid=1 with data 2'b00 for 4 cycles. mem is unchanged, wr_ready=0, loaded stays 1.
6. Reset mid-load: assert rst_n low after 3 beats. mem reads 0, loaded=0, state=IDLE; with no new start, further wr_valid has no effect.
